absdiff_scheduler: RTL

Shares one registered 4-bit compare/absolute-difference unit among several requesters. Requests are granted round-robin, and each accepted operand pair is computed once. The result is returned with the comparison outcome and the requester index. It sits between the operand sources and the consumer of difference/compare results, replacing per-source combinational subtractors.

---
 rtl/absdiff_pkg.sv | 14 +
 rtl/absdiff_scheduler_rr_arbiter.sv | 32 +++
 rtl/absdiff_scheduler.sv | 126 ++++++++++++
 3 files changed

// File: rtl/absdiff_pkg.sv
// Shared types and constants for the absdiff_scheduler block and its arbiter.
package absdiff_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] CMP_LT = 3'b001;
  localparam logic [2:0] CMP_GT = 3'b010;
  localparam logic [2:0] CMP_EQ = 3'b100;

endpackage

// File: rtl/absdiff_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N_REQ. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             found
);

  logic [ID_W-1:0] idx;

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ID_W'((int'(ptr) + i) % N_REQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

endmodule

// File: rtl/absdiff_scheduler.sv
// Shares one registered compare/|a-b| unit among N_REQ round-robin requesters.
// Optional ABSDIFF_SCHED_STATS_EN adds a saturating 16-bit txn_cnt output.
module absdiff_scheduler
  import absdiff_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef ABSDIFF_SCHED_STATS_EN
  output logic [15:0]            txn_cnt,
`endif
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_diff,
  output logic [2:0]             rsp_cmp
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

  state_t           state;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  cur_id;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_id;
  logic             grant_any;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req      (req_valid),
    .ptr      (rr_ptr),
    .grant    (grant),
    .grant_id (grant_id),
    .found    (grant_any)
  );

  // Accept is combinational so the requester sees it in the sampling cycle.
  assign req_ready = (state == IDLE && !rst) ? grant : '0;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cur_id    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_diff  <= '0;
      rsp_cmp   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            op_a   <= sel_a;
            op_b   <= sel_b;
            cur_id <= grant_id;
            state  <= CALC;
          end
        end
        CALC: begin
          rsp_id    <= cur_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
          // Always larger minus smaller, so the difference never wraps.
          if (op_a > op_b) begin
            rsp_cmp  <= CMP_GT;
            rsp_diff <= op_a - op_b;
          end else if (op_a < op_b) begin
            rsp_cmp  <= CMP_LT;
            rsp_diff <= op_b - op_a;
          end else begin
            rsp_cmp  <= CMP_EQ;
            rsp_diff <= '0;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= (cur_id == LAST_ID) ? '0 : cur_id + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ABSDIFF_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      txn_cnt <= '0;
    end else if (rsp_valid && rsp_ready && txn_cnt != 16'hFFFF) begin
      txn_cnt <= txn_cnt + 16'd1;
    end
  end
`endif

endmodule
